equiv_sweep_checker: RTL and testbench

//  Exhaustive sequential stimulus/response harness for the combinational test

---
 rtl/equiv_sweep_checker_if.sv | 42 ++++
 rtl/equiv_sweep_checker.sv | 157 +++++++++++++++
 tb/tb_equiv_sweep_checker.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/equiv_sweep_checker_if.sv
// Bus bundle for equiv_sweep_checker: sweep control, stimulus, DUT responses
// and result reporting. The slave modport is the checker; the master modport
// is the bench side that drives the two DUT copies.
// The optional signature output is present only when EQ_CHECK_MISR_EN is defined.
interface equiv_sweep_checker_if #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 2
);
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   vec_out;
    logic [N_OUT-1:0]  resp_a;
    logic [N_OUT-1:0]  resp_b;
    logic              busy;
    logic              done;
    logic              equiv;
    logic [N_IN-1:0]   fail_vec;
    logic [N_OUT-1:0]  fail_a;
    logic [N_OUT-1:0]  fail_b;
    logic [N_IN:0]     mismatch_cnt;
`ifdef EQ_CHECK_MISR_EN
    logic [15:0]       sig;

    modport slave (
        input  start, abort, resp_a, resp_b,
        output vec_out, busy, done, equiv, fail_vec, fail_a, fail_b, mismatch_cnt, sig
    );
    modport master (
        output start, abort, resp_a, resp_b,
        input  vec_out, busy, done, equiv, fail_vec, fail_a, fail_b, mismatch_cnt, sig
    );
`else
    modport slave (
        input  start, abort, resp_a, resp_b,
        output vec_out, busy, done, equiv, fail_vec, fail_a, fail_b, mismatch_cnt
    );
    modport master (
        output start, abort, resp_a, resp_b,
        input  vec_out, busy, done, equiv, fail_vec, fail_a, fail_b, mismatch_cnt
    );
`endif
endinterface

// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker: exhaustive sweep of all 2^N_IN input vectors into two
// combinational DUT copies, comparing their responses vector by vector and
// reporting equivalence, the first failing vector and the mismatch count.
// Optional feature macro: EQ_CHECK_MISR_EN adds a 16-bit MISR signature of resp_a.
module equiv_sweep_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    equiv_sweep_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    // Last settle count value; unused when SETTLE is 0 (SETTLE state never entered).
    localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0]  SETTLE_END  = SETTLE_LAST[3:0];
    localparam state_t      NEXT_VEC_ST = (SETTLE > 0) ? S_SETTLE : S_COMPARE;
    localparam logic [N_IN-1:0] VEC_ONE = 1;
    localparam logic [N_IN:0]   CNT_ONE = 1;

    state_t            state_q;
    logic [3:0]        settle_q;
    logic [N_IN-1:0]   vec_q;
    logic [N_IN-1:0]   vec_d;
    logic              busy_q;
    logic              done_q;
    logic              equiv_q;
    logic [N_IN-1:0]   fail_vec_q;
    logic [N_OUT-1:0]  fail_a_q;
    logic [N_OUT-1:0]  fail_b_q;
    logic [N_IN:0]     cnt_q;
    logic [N_IN:0]     cnt_d;
    logic              mismatch;
    logic              last_vec;
`ifdef EQ_CHECK_MISR_EN
    logic [15:0]       sig_q;
    logic [15:0]       sig_d;
`endif

    // Next-value helpers for the sweep datapath
    always_comb begin
        vec_d    = vec_q + VEC_ONE;
        cnt_d    = cnt_q + CNT_ONE;
        mismatch = (bus.resp_a != bus.resp_b);
        last_vec = &vec_q;
`ifdef EQ_CHECK_MISR_EN
        sig_d    = {sig_q[14:0], sig_q[15] ^ sig_q[11] ^ sig_q[4]} ^ 16'(bus.resp_a);
`endif
    end

    // Sweep FSM with all outputs registered; done defaults low so it pulses once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            equiv_q    <= 1'b0;
            fail_vec_q <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            cnt_q      <= '0;
`ifdef EQ_CHECK_MISR_EN
            sig_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        vec_q      <= '0;
                        cnt_q      <= '0;
                        fail_vec_q <= '0;
                        fail_a_q   <= '0;
                        fail_b_q   <= '0;
                        equiv_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        settle_q   <= '0;
`ifdef EQ_CHECK_MISR_EN
                        sig_q      <= '0;
`endif
                        state_q    <= NEXT_VEC_ST;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        equiv_q  <= 1'b0;
                        settle_q <= '0;
                    end else if (settle_q == SETTLE_END) begin
                        settle_q <= '0;
                        state_q  <= S_COMPARE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_COMPARE: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        equiv_q <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            cnt_q   <= cnt_d;
                            equiv_q <= 1'b0;
                            if (cnt_q == '0) begin
                                fail_vec_q <= vec_q;
                                fail_a_q   <= bus.resp_a;
                                fail_b_q   <= bus.resp_b;
                            end
                        end
`ifdef EQ_CHECK_MISR_EN
                        sig_q <= sig_d;
`endif
                        if (last_vec) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q   <= vec_d;
                            state_q <= NEXT_VEC_ST;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.vec_out      = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.equiv        = equiv_q;
    assign bus.fail_vec     = fail_vec_q;
    assign bus.fail_a       = fail_a_q;
    assign bus.fail_b       = fail_b_q;
    assign bus.mismatch_cnt = cnt_q;
`ifdef EQ_CHECK_MISR_EN
    assign bus.sig          = sig_q;
`endif

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Bench for equiv_sweep_checker: two checker instances (SETTLE=1 and SETTLE=0)
// share truth tables that emulate DUT copies A and B; results are checked
// against a table-walking reference model. EQ_CHECK_MISR_EN adds signature checks.
module tb_equiv_sweep_checker;

    localparam int unsigned N_IN  = 2;
    localparam int unsigned N_OUT = 2;
    localparam int unsigned NV    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [N_OUT-1:0] tt_a [NV];
    logic [N_OUT-1:0] tt_b [NV];

    equiv_sweep_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if1 ();
    equiv_sweep_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if0 ();

    equiv_sweep_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );
    equiv_sweep_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );

    assign if1.resp_a = tt_a[if1.vec_out];
    assign if1.resp_b = tt_b[if1.vec_out];
    assign if0.resp_a = tt_a[if0.vec_out];
    assign if0.resp_b = tt_b[if0.vec_out];

    function automatic logic [1:0] f_or(input logic [1:0] v);
        return {~v[1], v[0] | v[1]};
    endfunction
    function automatic logic [1:0] f_xor(input logic [1:0] v);
        return {~v[1], v[0] ^ v[1]};
    endfunction

    task automatic load_scenario(input bit use_xor);
        logic [1:0] v;
        for (int i = 0; i < NV; i++) begin
            v = 2'(i);
            tt_a[i] = f_or(v);
            tt_b[i] = use_xor ? f_xor(v) : f_or(v);
        end
    endtask

    task automatic set_start(input int sel, input logic val);
        if (sel == 1) if1.start = val; else if0.start = val;
    endtask

    // Runs one sweep; checks busy/done timing every cycle and the final results
    task automatic run_sweep(input int sel, input int pulse_at, input string name);
        int                len;
        logic              b, d, eq;
        logic [N_IN:0]     cnt;
        logic [N_IN-1:0]   fv;
        logic [N_OUT-1:0]  fa, fb;
        logic              x_eq;
        logic [N_IN:0]     x_cnt;
        logic [N_IN-1:0]   x_fv;
        logic [N_OUT-1:0]  x_fa, x_fb;
`ifdef EQ_CHECK_MISR_EN
        logic [15:0]       s, x_s;
`endif
        len = NV * ((sel == 1) ? 2 : 1);
        x_cnt = '0; x_fv = '0; x_fa = '0; x_fb = '0;
`ifdef EQ_CHECK_MISR_EN
        x_s = '0;
`endif
        for (int v = 0; v < NV; v++) begin
            if (tt_a[v] != tt_b[v]) begin
                if (x_cnt == 0) begin
                    x_fv = N_IN'(v); x_fa = tt_a[v]; x_fb = tt_b[v];
                end
                x_cnt = x_cnt + 1'b1;
            end
`ifdef EQ_CHECK_MISR_EN
            x_s = {x_s[14:0], x_s[15] ^ x_s[11] ^ x_s[4]} ^ 16'(tt_a[v]);
`endif
        end
        x_eq = (x_cnt == 0);

        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        for (int j = 0; j <= len + 1; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (j == pulse_at) set_start(sel, 1'b1);
            if (j == pulse_at + 1) set_start(sel, 1'b0);
            b = (sel == 1) ? if1.busy : if0.busy;
            d = (sel == 1) ? if1.done : if0.done;
            tests++;
            if (b !== (j < len) || d !== (j == len)) begin
                fails++;
                $display("FAIL %s timing j=%0d: busy=%b done=%b, expected busy=%b done=%b",
                         name, j, b, d, (j < len), (j == len));
            end
        end
        if (sel == 1) begin
            eq = if1.equiv; cnt = if1.mismatch_cnt; fv = if1.fail_vec; fa = if1.fail_a; fb = if1.fail_b;
`ifdef EQ_CHECK_MISR_EN
            s = if1.sig;
`endif
        end else begin
            eq = if0.equiv; cnt = if0.mismatch_cnt; fv = if0.fail_vec; fa = if0.fail_a; fb = if0.fail_b;
`ifdef EQ_CHECK_MISR_EN
            s = if0.sig;
`endif
        end
        tests++;
        if (eq !== x_eq) begin
            fails++; $display("FAIL %s equiv: got %b expected %b", name, eq, x_eq);
        end
        tests++;
        if (cnt !== x_cnt) begin
            fails++; $display("FAIL %s mismatch_cnt: got %0d expected %0d", name, cnt, x_cnt);
        end
        tests++;
        if (fv !== x_fv || fa !== x_fa || fb !== x_fb) begin
            fails++;
            $display("FAIL %s fail_vec/a/b: got %b/%b/%b expected %b/%b/%b", name, fv, fa, fb, x_fv, x_fa, x_fb);
        end
`ifdef EQ_CHECK_MISR_EN
        tests++;
        if (s !== x_s) begin
            fails++; $display("FAIL %s sig: got %h expected %h", name, s, x_s);
        end
`endif
    endtask

    task automatic test_reset();
        if1.start = 1'b0; if1.abort = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        load_scenario(1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.equiv !== 1'b0 || if1.vec_out !== '0 ||
            if1.mismatch_cnt !== '0 || if1.fail_vec !== '0 || if1.fail_a !== '0 || if1.fail_b !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b equiv=%b vec=%b cnt=%0d, expected all zero",
                     if1.busy, if1.done, if1.equiv, if1.vec_out, if1.mismatch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0/0", if1.busy, if1.done);
        end
    endtask

    task automatic test_equal();
        load_scenario(1'b0);
        run_sweep(1, -1, "equal");
    endtask

    task automatic test_mismatch();
        load_scenario(1'b1);
        run_sweep(1, -1, "mismatch");
        tests++;
        if (if1.fail_vec !== 2'b11 || if1.fail_a !== 2'b01 || if1.fail_b !== 2'b00 || if1.mismatch_cnt !== 3'd1) begin
            fails++;
            $display("FAIL mismatch_const: vec=%b a=%b b=%b cnt=%0d expected 11/01/00/1",
                     if1.fail_vec, if1.fail_a, if1.fail_b, if1.mismatch_cnt);
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        load_scenario(1'b0);
        @(negedge clk);
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (if1.vec_out !== 2'd1) begin
            fails++; $display("FAIL abort_pre_vec: got %b expected 01", if1.vec_out);
        end
        if1.abort = 1'b1;
        @(posedge clk);
        #1;
        if1.abort = 1'b0;
        tests++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.equiv !== 1'b0 || if1.vec_out !== 2'd1) begin
            fails++;
            $display("FAIL abort_state: busy=%b done=%b equiv=%b vec=%b expected 0/0/0/01",
                     if1.busy, if1.done, if1.equiv, if1.vec_out);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (if1.done === 1'b1 || if1.busy === 1'b1) seen_done = 1'b1;
        end
        tests++;
        if (seen_done !== 1'b0) begin
            fails++; $display("FAIL abort_no_done: activity seen=%b expected 0", seen_done);
        end
        run_sweep(1, -1, "after_abort");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NV; i++) begin
            tt_a[i] = 2'(i);
            tt_b[i] = (i == 0) ? 2'b11 : 2'(i);
        end
        @(negedge clk);
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (if1.busy !== 1'b1 || if1.vec_out !== 2'd2 || if1.mismatch_cnt !== 3'd1 || if1.fail_b !== 2'b11) begin
            fails++;
            $display("FAIL async_pre: busy=%b vec=%b cnt=%0d fail_b=%b expected 1/10/1/11",
                     if1.busy, if1.vec_out, if1.mismatch_cnt, if1.fail_b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (if1.busy !== 1'b0 || if1.vec_out !== '0 || if1.mismatch_cnt !== '0 || if1.fail_b !== '0 ||
            if1.fail_a !== '0 || if1.equiv !== 1'b0 || if1.done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: busy=%b vec=%b cnt=%0d fail_a=%b fail_b=%b equiv=%b expected zeros",
                     if1.busy, if1.vec_out, if1.mismatch_cnt, if1.fail_a, if1.fail_b, if1.equiv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            tests++;
            if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin
                fails++; $display("FAIL async_no_done: busy=%b done=%b expected 0/0", if1.busy, if1.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_scenario(1'b0);
        run_sweep(1, 2, "start_ignored");
        run_sweep(0, -1, "settle0_equal");
        load_scenario(1'b1);
        run_sweep(0, 1, "settle0_mismatch");
        // start together with abort in IDLE must not begin a sweep
        @(negedge clk);
        if1.start = 1'b1; if1.abort = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0; if1.abort = 1'b0;
        tests++;
        if (if1.busy !== 1'b0) begin
            fails++; $display("FAIL start_abort_idle: busy=%b expected 0", if1.busy);
        end
    endtask

    task automatic test_random();
        logic [N_OUT-1:0] mask;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NV; i++) begin
                tt_a[i] = N_OUT'($urandom);
                mask = ($urandom_range(0, 2) == 0) ? N_OUT'($urandom_range(1, 3)) : '0;
                tt_b[i] = tt_a[i] ^ mask;
            end
            run_sweep(it % 2, ($urandom_range(0, 3) == 0) ? 3 : -1, "random");
        end
    endtask

`ifdef EQ_CHECK_MISR_EN
    task automatic test_misr();
        for (int i = 0; i < NV; i++) begin tt_a[i] = '0; tt_b[i] = '0; end
        run_sweep(1, -1, "misr_zero");
        tests++;
        if (if1.sig !== 16'h0000) begin
            fails++; $display("FAIL misr_zero_const: got %h expected 0000", if1.sig);
        end
        for (int i = 0; i < NV; i++) begin tt_a[i] = 2'b01; tt_b[i] = 2'b01; end
        run_sweep(1, -1, "misr_ones");
        tests++;
        if (if1.sig !== 16'h000F) begin
            fails++; $display("FAIL misr_ones_const: got %h expected 000f", if1.sig);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_equal();
        test_mismatch();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef EQ_CHECK_MISR_EN
        test_misr();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
